// File: rtl/input_buffer.sv
// rtl/input_buffer.sv - assembles received bytes into 128-bit blocks and queues them for the AES core
//
// Ports:
//   clk, reset         system clock; synchronous active-high reset
//   rx_done, rx_byte   one-cycle byte strobe and data from the UART receiver
//   text_out           head FIFO block, byte 0 (first received) in bits 127:120
//   text_valid         FIFO not empty
//   text_ready         AES core accepts text_out (pop)
//   fifo_count         blocks queued, 0..FIFO_DEPTH
//   byte_index         bytes captured in the current partial block
//   overrun            sticky: a byte arrived while a finished block was waiting
//   timeout            one-cycle pulse: stale partial block discarded

module input_buffer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_done,
  input  logic [7:0]                    rx_byte,
  output logic [127:0]                  text_out,
  output logic                          text_valid,
  input  logic                          text_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [3:0]                    byte_index,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    STALL   = 2'd2
  } state_t;

  state_t          state;
  logic [127:0]    asm_reg;
  logic [127:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   to_cnt;
  logic            push;
  logic            pop;

  // Fullness is judged on the count at the start of the cycle, so a pop in
  // the same cycle never lets a waiting block in; it goes next cycle.
  assign push       = (state != COLLECT) && (fifo_count != FULL);
  assign pop        = (fifo_count != '0) && text_ready;
  assign text_valid = (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      asm_reg    <= '0;
      byte_index <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      text_out   <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      to_cnt     <= '0;
    end else begin
      timeout <= 1'b0;

      if (push) begin
        mem[wr_ptr] <= asm_reg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase

      // text_out is a registered copy of the head so it keeps the last
      // block when the FIFO drains. When the only entry is popped while a
      // new one is pushed, the pushed block becomes the head directly.
      if (push && (fifo_count == '0)) begin
        text_out <= asm_reg;
      end else if (pop) begin
        if (fifo_count > CW'(1)) begin
          text_out <= mem[rd_ptr + 1'b1];
        end else if (push) begin
          text_out <= asm_reg;
        end
      end

      case (state)
        COLLECT: begin
          if (rx_done) begin
            asm_reg[{4'd15 - byte_index, 3'b000} +: 8] <= rx_byte;
            byte_index <= byte_index + 1'b1;
            to_cnt     <= '0;
            if (byte_index == 4'd15) begin
              state <= WRITE;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (byte_index != 4'd0)) begin
            if (to_cnt == TO_LAST) begin
              byte_index <= '0;
              to_cnt     <= '0;
              timeout    <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        WRITE, STALL: begin
          // A finished block is waiting in asm_reg; incoming bytes are lost.
          if (rx_done) begin
            overrun <= 1'b1;
          end
          state <= push ? COLLECT : STALL;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// tb/tb_input_buffer.sv - self-checking bench for input_buffer

module tb_input_buffer;

  localparam int DEPTH = 4;
  localparam int TMO   = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_done;
  logic [7:0]   rx_byte;
  logic [127:0] text_out;
  logic         text_valid;
  logic         text_ready;
  logic [2:0]   fifo_count;
  logic [3:0]   byte_index;
  logic         overrun;
  logic         timeout;

  always #5 clk = ~clk;

  input_buffer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_done    (rx_done),
    .rx_byte    (rx_byte),
    .text_out   (text_out),
    .text_valid (text_valid),
    .text_ready (text_ready),
    .fifo_count (fifo_count),
    .byte_index (byte_index),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queued blocks, bytes of the partial block, and one
  // finished block waiting for room.
  logic [127:0] m_q[$];
  logic [7:0]   m_part[$];
  bit           m_pend;
  logic [127:0] m_pend_blk;
  bit           m_ovr;
  bit           m_tmo;
  int           m_idle;
  logic [127:0] m_head;

  logic [127:0] popped[$];
  int           tmo_seen;

  typedef struct {
    bit         rst;
    bit         rxd;
    logic [7:0] b;
    bit         rdy;
    logic [3:0] e_idx;
    logic [2:0] e_cnt;
    bit         e_val;
    bit         e_ovr;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [7:0] base);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], 8'(base + 8'(i))};
    return r;
  endfunction

  function automatic void model_step(input bit rst, input bit rxd, input logic [7:0] b, input bit rdy);
    int n;
    bit do_pop;
    bit do_push;
    logic [127:0] acc;
    if (rst) begin
      m_q.delete(); m_part.delete();
      m_pend = 0; m_ovr = 0; m_tmo = 0; m_idle = 0; m_head = '0;
      return;
    end
    n       = m_q.size();
    m_tmo   = 0;
    do_pop  = (n > 0) && rdy;
    do_push = m_pend && (n < DEPTH);
    if (do_pop)  void'(m_q.pop_front());
    if (do_push) m_q.push_back(m_pend_blk);
    if (m_pend) begin
      if (rxd) m_ovr = 1;
      if (do_push) m_pend = 0;
    end else if (rxd) begin
      m_part.push_back(b);
      m_idle = 0;
      if (m_part.size() == 16) begin
        acc = '0;
        foreach (m_part[i]) acc = {acc[119:0], m_part[i]};
        m_pend_blk = acc;
        m_pend = 1;
        m_part.delete();
      end
    end else if (m_part.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_part.delete();
        m_idle = 0;
        m_tmo = 1;
      end
    end
    if (m_q.size() > 0) m_head = m_q[0];
  endfunction

  task automatic cycle(input bit rst, input bit rxd, input logic [7:0] b, input bit rdy);
    reset = rst; rx_done = rxd; rx_byte = b; text_ready = rdy;
    if (!rst && (text_valid === 1'b1) && rdy) popped.push_back(text_out);
    @(posedge clk);
    model_step(rst, rxd, b, rdy);
    #1;
    check("text_valid", 128'(text_valid), 128'(m_q.size() > 0));
    check("fifo_count", 128'(fifo_count), 128'(m_q.size()));
    check("byte_index", 128'(byte_index), 128'(m_part.size()));
    check("overrun",    128'(overrun),    128'(m_ovr));
    check("timeout",    128'(timeout),    128'(m_tmo));
    check("text_out",   text_out,         m_head);
    if (timeout === 1'b1) tmo_seen++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, rdy);
  endtask

  task automatic send_block(input logic [7:0] base, input int gap, input bit rdy);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 8'(base + 8'(i)), rdy);
      idle(gap, rdy);
    end
  endtask

  initial begin
    int rdy_bias;
    reset = 1; rx_done = 0; rx_byte = 0; text_ready = 0;

    tbl[0] = '{1, 0, 8'h00, 0, 4'd0, 3'd0, 0, 0};
    tbl[1] = '{0, 1, 8'h55, 0, 4'd1, 3'd0, 0, 0};
    tbl[2] = '{0, 1, 8'h66, 0, 4'd2, 3'd0, 0, 0};
    tbl[3] = '{0, 0, 8'h00, 0, 4'd2, 3'd0, 0, 0};
    tbl[4] = '{0, 1, 8'h77, 0, 4'd3, 3'd0, 0, 0};
    tbl[5] = '{1, 0, 8'h00, 0, 4'd0, 3'd0, 0, 0};
    tbl[6] = '{0, 0, 8'h00, 1, 4'd0, 3'd0, 0, 0};
    tbl[7] = '{0, 1, 8'h11, 1, 4'd1, 3'd0, 0, 0};

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].rst, tbl[i].rxd, tbl[i].b, tbl[i].rdy);
      check("tbl byte_index", 128'(byte_index), 128'(tbl[i].e_idx));
      check("tbl fifo_count", 128'(fifo_count), 128'(tbl[i].e_cnt));
      check("tbl text_valid", 128'(text_valid), 128'(tbl[i].e_val));
      check("tbl overrun",    128'(overrun),    128'(tbl[i].e_ovr));
      if (i == 0) begin
        check("reset text_out", text_out, 128'h0);
        check("reset timeout",  128'(timeout), 128'h0);
      end
    end

    // Single block, spaced bytes, consumer always ready.
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 15; i++) begin
      cycle(0, 1, 8'(i), 1);
      idle(19, 1);
    end
    cycle(0, 1, 8'h0F, 1);
    check("t1 valid after 16th", 128'(text_valid), 128'h0);
    idle(1, 1);
    check("t1 valid at push", 128'(text_valid), 128'h1);
    check("t1 text_out", text_out, 128'h000102030405060708090A0B0C0D0E0F);
    idle(1, 1);
    check("t1 valid after pop", 128'(text_valid), 128'h0);
    check("t1 fifo_count", 128'(fifo_count), 128'h0);

    // Fill FIFO, stall a fifth block, drop bytes, then drain.
    cycle(1, 0, 8'h00, 0);
    for (int b = 0; b < 5; b++) send_block(8'(b * 16), 1, 0);
    idle(2, 0);
    check("t2 fifo full", 128'(fifo_count), 128'd4);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 8'(8'hE0 + 8'(i)), 0);
      idle(1, 0);
    end
    check("t2 overrun", 128'(overrun), 128'h1);
    check("t2 byte_index", 128'(byte_index), 128'h0);
    popped.delete();
    idle(10, 1);
    check("t2 pop count", 128'(popped.size()), 128'd5);
    foreach (popped[i]) check("t2 pop order", popped[i], blk(8'(i * 16)));
    check("t2 overrun sticky", 128'(overrun), 128'h1);

    // Partial block timeout, then a clean block.
    cycle(1, 0, 8'h00, 1);
    for (int i = 0; i < 7; i++) cycle(0, 1, 8'(8'h70 + 8'(i)), 1);
    tmo_seen = 0;
    idle(49, 1);
    check("t3 no early timeout", 128'(tmo_seen), 128'h0);
    idle(1, 1);
    check("t3 timeout pulse", 128'(timeout), 128'h1);
    check("t3 byte_index", 128'(byte_index), 128'h0);
    idle(1, 1);
    check("t3 single pulse", 128'(tmo_seen), 128'h1);
    popped.delete();
    send_block(8'hA0, 0, 1);
    idle(2, 1);
    check("t3 pop count", 128'(popped.size()), 128'd1);
    if (popped.size() > 0) check("t3 block", popped[0], blk(8'hA0));

    // 17 back-to-back bytes: the 17th lands in WRITE and is dropped.
    cycle(1, 0, 8'h00, 1);
    popped.delete();
    for (int i = 0; i < 17; i++) cycle(0, 1, 8'(8'h30 + 8'(i)), 1);
    check("t5 overrun", 128'(overrun), 128'h1);
    idle(3, 1);
    check("t5 pop count", 128'(popped.size()), 128'd1);
    if (popped.size() > 0) check("t5 block", popped[0], blk(8'h30));
    check("t5 byte_index", 128'(byte_index), 128'h0);

    // Reset mid-block with two blocks queued and overrun set.
    cycle(1, 0, 8'h00, 0);
    send_block(8'h00, 0, 0);
    idle(1, 0);
    send_block(8'h40, 0, 0);
    cycle(0, 1, 8'hEE, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 8'(8'h50 + 8'(i)), 0);
    check("t4 queued", 128'(fifo_count), 128'd2);
    check("t4 partial", 128'(byte_index), 128'd9);
    check("t4 overrun set", 128'(overrun), 128'h1);
    cycle(1, 0, 8'h00, 0);
    check("t4 valid", 128'(text_valid), 128'h0);
    check("t4 count", 128'(fifo_count), 128'h0);
    check("t4 idx", 128'(byte_index), 128'h0);
    check("t4 ovr", 128'(overrun), 128'h0);
    popped.delete();
    send_block(8'h10, 0, 1);
    idle(3, 1);
    check("t4 pop count", 128'(popped.size()), 128'd1);
    if (popped.size() > 0) check("t4 block", popped[0], blk(8'h10));

    // Push and pop in the same cycle with two blocks queued.
    cycle(1, 0, 8'h00, 0);
    send_block(8'h00, 0, 0);
    idle(1, 0);
    send_block(8'h10, 0, 0);
    idle(1, 0);
    check("t6 count before", 128'(fifo_count), 128'd2);
    popped.delete();
    send_block(8'h20, 0, 0);
    cycle(0, 0, 8'h00, 1);
    check("t6 count same", 128'(fifo_count), 128'd2);
    idle(4, 1);
    check("t6 pop count", 128'(popped.size()), 128'd3);
    foreach (popped[i]) check("t6 pop order", popped[i], blk(8'(i * 16)));

    // Randomized traffic against the model.
    cycle(1, 0, 8'h00, 0);
    rdy_bias = 2;
    for (int n = 0; n < 4000; n++) begin
      int r;
      if (n % 200 == 0) rdy_bias = $urandom_range(0, 4);
      r = $urandom_range(0, 299);
      if (r == 0) cycle(1, 0, 8'h00, 0);
      else if (r < 4) idle(55, $urandom_range(0, 3) < rdy_bias);
      else cycle(0, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) < rdy_bias);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
